fft_piso: RTL



---
 rtl/fas_pkg.sv | 31 +++
 rtl/fft_frame_buf.sv | 32 +++
 rtl/fft_piso.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fas_pkg.sv
// Shared constants, bin/frame types and FSM encoding for the FFT PISO stage.
// FFT_PISO_HALF_SPECTRUM_EN keeps only bins 0..NBIN/2 (the non-mirrored half).
package fas_pkg;

   localparam int unsigned NBIN = 16;
   localparam int unsigned DW   = 32;
   localparam int unsigned IW   = 4;
   localparam int unsigned HW   = DW / 2;

`ifdef FFT_PISO_HALF_SPECTRUM_EN
   localparam int unsigned LASTIDX = NBIN / 2;
`else
   localparam int unsigned LASTIDX = NBIN - 1;
`endif

   // Number of bins actually held in each buffer.
   localparam int unsigned NSTORE = LASTIDX + 1;

   typedef struct packed {
      logic signed [HW-1:0] re;
      logic signed [HW-1:0] im;
   } bin_t;

   typedef bin_t [NSTORE-1:0] frame_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/fft_frame_buf.sv
// One-frame register bank: whole-frame load, whole-frame read-out and a
// single-bin read mux.
module fft_frame_buf
   import fas_pkg::*;
(
   input  logic          clk,
   input  logic          load_i,
   input  frame_t        frame_i,
   input  logic [IW-1:0] idx_i,
   output frame_t        frame_o,
   output bin_t          bin_o
);

   frame_t mem_q;

   // Contents carry no reset; validity is tracked by the owner's flags.
   always_ff @(posedge clk) begin
      if (load_i) begin
         mem_q <= frame_i;
      end
   end

   assign frame_o = mem_q;

   always_comb begin
      bin_o = '0;
      if (32'(idx_i) < NSTORE) begin
         bin_o = mem_q[idx_i];
      end
   end

endmodule

// File: rtl/fft_piso.sv
// FFT frame parallel-in/serial-out with a one-frame shadow buffer and
// valid/ready output. FFT_PISO_HALF_SPECTRUM_EN emits bins 0..NBIN/2 only.
module fft_piso
   import fas_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               fft_valid,
   input  logic [NBIN*DW-1:0] fft_bus,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DW-1:0]      out_d,
   output logic [IW-1:0]      out_idx,
   output logic               out_last,
   output logic               busy,
   output logic               frame_drop
);

   state_t        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic          shd_full_q, shd_full_d;
   logic          act_ld_fft, act_ld_shd, shd_ld, drop;
   logic          hs, last_hs, send_d;
   frame_t        fft_frame, act_in, shd_frame, unused_act_frame;
   bin_t          act_bin, shd_bin0, nxt_bin;

`ifdef FFT_PISO_HALF_SPECTRUM_EN
   logic unused_mirror_bins;
   assign unused_mirror_bins = ^fft_bus[NBIN*DW-1:NSTORE*DW];
`endif

   assign fft_frame = fft_bus[NSTORE*DW-1:0];
   assign act_in    = act_ld_shd ? shd_frame : fft_frame;

   fft_frame_buf u_act (
      .clk     (clk),
      .load_i  (act_ld_fft | act_ld_shd),
      .frame_i (act_in),
      .idx_i   (cnt_d),
      .frame_o (unused_act_frame),
      .bin_o   (act_bin)
   );

   fft_frame_buf u_shd (
      .clk     (clk),
      .load_i  (shd_ld),
      .frame_i (fft_frame),
      .idx_i   ('0),
      .frame_o (shd_frame),
      .bin_o   (shd_bin0)
   );

   assign hs      = (state_q == SEND) && out_ready;
   assign last_hs = hs && (cnt_q == IW'(LASTIDX));

   // Next-state, buffer steering and counter.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shd_full_d = shd_full_q;
      act_ld_fft = 1'b0;
      act_ld_shd = 1'b0;
      shd_ld     = 1'b0;
      drop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fft_valid) begin
               act_ld_fft = 1'b1;
               cnt_d      = '0;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (hs) begin
               cnt_d = cnt_q + IW'(1);
            end
            if (last_hs) begin
               cnt_d = '0;
               if (shd_full_q) begin
                  act_ld_shd = 1'b1;
                  shd_full_d = fft_valid;
                  shd_ld     = fft_valid;
               end else if (fft_valid) begin
                  act_ld_fft = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (fft_valid) begin
               if (shd_full_q) begin
                  drop = 1'b1;
               end else begin
                  shd_ld     = 1'b1;
                  shd_full_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from next-state, so the word shown matches cnt_d.
   always_comb begin
      send_d  = (state_d == SEND);
      nxt_bin = act_bin;
      if (act_ld_fft) begin
         nxt_bin = fft_frame[0];
      end else if (act_ld_shd) begin
         nxt_bin = shd_bin0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shd_full_q <= 1'b0;
         out_valid  <= 1'b0;
         out_d      <= '0;
         out_idx    <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         frame_drop <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shd_full_q <= shd_full_d;
         out_valid  <= send_d;
         out_d      <= send_d ? nxt_bin : '0;
         out_idx    <= cnt_d;
         out_last   <= send_d && (cnt_d == IW'(LASTIDX));
         busy       <= send_d || shd_full_d;
         frame_drop <= drop;
      end
   end

endmodule
